// File: rtl/ln_dat_out_axi_writer.sv
// AXI4 write master draining the LN/RMSNorm result stream to HBM in feature-map order:
// one pixel per beat, rows split into INCR bursts that never cross a line.
module ln_dat_out_axi_writer #(
    parameter int AXI_DW    = 256,
    parameter int AXI_AW    = 32,
    parameter int ID_W      = 4,
    parameter int PIX_BYTES = 32,
    parameter int MAX_BURST = 16,
    parameter int DIM_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIM_W-1:0]      win,
    input  logic [DIM_W-1:0]      hin,
    input  logic [DIM_W-1:0]      ch_groups,
    input  logic [AXI_AW-1:0]     base_addr,
    input  logic [AXI_AW-1:0]     surface_stride,
    input  logic [AXI_AW-1:0]     line_stride,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [AXI_DW-1:0]     s_data,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [AXI_AW-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic [ID_W-1:0]       m_awid,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [AXI_DW-1:0]     m_wdata,
    output logic [AXI_DW/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int SIZE_LOG2 = $clog2(PIX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  win_q, win_d;
    logic [DIM_W-1:0]  hin_q, hin_d;
    logic [DIM_W-1:0]  cg_q, cg_d;
    logic [AXI_AW-1:0] ls_q, ls_d;
    logic [AXI_AW-1:0] ss_q, ss_d;
    logic [AXI_AW-1:0] surf_base_q, surf_base_d;
    logic [AXI_AW-1:0] line_base_q, line_base_d;
    logic [AXI_AW-1:0] addr_q, addr_d;
    logic [DIM_W-1:0]  w_rem_q, w_rem_d;
    logic [DIM_W-1:0]  h_q, h_d;
    logic [DIM_W-1:0]  g_q, g_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_q, beat_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DIM_W-1:0]  burst_beats;
    logic [7:0]        awlen_c;
    logic [AXI_AW-1:0] next_line_base;
    logic [AXI_AW-1:0] next_surf_base;

    // w_rem counts pixels of the current line not yet written; it drives the next burst length.
    always_comb begin
        if (w_rem_q > DIM_W'(MAX_BURST)) begin
            burst_beats = DIM_W'(MAX_BURST);
        end else begin
            burst_beats = w_rem_q;
        end
        awlen_c = 8'(burst_beats - DIM_W'(1));
    end

    assign next_line_base = line_base_q + ls_q;
    assign next_surf_base = surf_base_q + ss_q;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        hin_d       = hin_q;
        cg_d        = cg_q;
        ls_d        = ls_q;
        ss_d        = ss_q;
        surf_base_d = surf_base_q;
        line_base_d = line_base_q;
        addr_d      = addr_q;
        w_rem_d     = w_rem_q;
        h_d         = h_q;
        g_d         = g_q;
        len_d       = len_q;
        beat_d      = beat_q;
        err_d       = err_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    win_d       = win;
                    hin_d       = hin;
                    cg_d        = ch_groups;
                    ls_d        = line_stride;
                    ss_d        = surface_stride;
                    surf_base_d = base_addr;
                    line_base_d = base_addr;
                    addr_d      = base_addr;
                    w_rem_d     = win;
                    h_d         = '0;
                    g_d         = '0;
                    beat_d      = '0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    if ((win == '0) || (hin == '0) || (ch_groups == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_AW;
                    end
                end
            end

            S_AW: begin
                if (m_awready) begin
                    len_d   = awlen_c;
                    beat_d  = '0;
                    state_d = S_W;
                end
            end

            S_W: begin
                if (s_valid && m_wready) begin
                    beat_d  = beat_q + 8'd1;
                    addr_d  = addr_q + AXI_AW'(PIX_BYTES);
                    w_rem_d = w_rem_q - DIM_W'(1);
                    if (beat_q == len_q) begin
                        state_d = S_B;
                    end
                end
            end

            S_B: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    // addr_q already points past the last beat when the line continues.
                    if (w_rem_q != '0) begin
                        state_d = S_AW;
                    end else if (h_q != (hin_q - DIM_W'(1))) begin
                        h_d         = h_q + DIM_W'(1);
                        line_base_d = next_line_base;
                        addr_d      = next_line_base;
                        w_rem_d     = win_q;
                        state_d     = S_AW;
                    end else if (g_q != (cg_q - DIM_W'(1))) begin
                        g_d         = g_q + DIM_W'(1);
                        h_d         = '0;
                        surf_base_d = next_surf_base;
                        line_base_d = next_surf_base;
                        addr_d      = next_surf_base;
                        w_rem_d     = win_q;
                        state_d     = S_AW;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            hin_q       <= '0;
            cg_q        <= '0;
            ls_q        <= '0;
            ss_q        <= '0;
            surf_base_q <= '0;
            line_base_q <= '0;
            addr_q      <= '0;
            w_rem_q     <= '0;
            h_q         <= '0;
            g_q         <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            hin_q       <= hin_d;
            cg_q        <= cg_d;
            ls_q        <= ls_d;
            ss_q        <= ss_d;
            surf_base_q <= surf_base_d;
            line_base_q <= line_base_d;
            addr_q      <= addr_d;
            w_rem_q     <= w_rem_d;
            h_q         <= h_d;
            g_q         <= g_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // W channel is a zero-latency pass-through of the result stream.
    assign m_awvalid = (state_q == S_AW);
    assign m_awaddr  = addr_q;
    assign m_awlen   = (state_q == S_AW) ? awlen_c : 8'd0;
    assign m_awsize  = 3'(SIZE_LOG2);
    assign m_awburst = 2'b01;
    assign m_awid    = '0;
    assign m_wvalid  = (state_q == S_W) && s_valid;
    assign s_ready   = (state_q == S_W) && m_wready;
    assign m_wdata   = (state_q == S_W) ? s_data : '0;
    assign m_wstrb   = '1;
    assign m_wlast   = (state_q == S_W) && (beat_q == len_q);
    assign m_bready  = (state_q == S_B);
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ln_dat_out_axi_writer.sv
// Bench for ln_dat_out_axi_writer: table of transfer configurations run against an AXI slave
// model with a memory image, plus hand-written zero-size and mid-burst reset sequences.
module tb_ln_dat_out_axi_writer;
    localparam int AXI_DW = 256, AXI_AW = 32, ID_W = 4, PIX_BYTES = 32, MAX_BURST = 16, DIM_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                start = 1'b0;
    logic [DIM_W-1:0]    win = '0, hin = '0, ch_groups = '0;
    logic [AXI_AW-1:0]   base_addr = '0, surface_stride = '0, line_stride = '0;
    logic                s_valid = 1'b0, s_ready;
    logic [AXI_DW-1:0]   s_data = '0;
    logic                m_awvalid, m_awready = 1'b0;
    logic [AXI_AW-1:0]   m_awaddr;
    logic [7:0]          m_awlen;
    logic [2:0]          m_awsize;
    logic [1:0]          m_awburst;
    logic [ID_W-1:0]     m_awid;
    logic                m_wvalid, m_wready = 1'b0;
    logic [AXI_DW-1:0]   m_wdata;
    logic [AXI_DW/8-1:0] m_wstrb;
    logic                m_wlast;
    logic                m_bvalid = 1'b0, m_bready;
    logic [1:0]          m_bresp = 2'b00;
    logic                busy, done, err;

    ln_dat_out_axi_writer #(
        .AXI_DW(AXI_DW), .AXI_AW(AXI_AW), .ID_W(ID_W), .PIX_BYTES(PIX_BYTES),
        .MAX_BURST(MAX_BURST), .DIM_W(DIM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .win(win), .hin(hin), .ch_groups(ch_groups),
        .base_addr(base_addr), .surface_stride(surface_stride), .line_stride(line_stride),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pix(input int idx);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(idx) + (32'(k) << 24);
        return r;
    endfunction

    typedef struct {
        int          win;
        int          hin;
        int          cg;
        logic [31:0] base;
        logic [31:0] ss;
        logic [31:0] ls;
        int          stalls;
        int          err_burst;
        int          stray;
        int          exp_bursts;
        int          exp_err;
        int          seq;
    } vec_t;

    vec_t vecs[7];

    logic [255:0] mem [logic [31:0]];
    logic [31:0]  aw_addrs[$];
    logic [7:0]   aw_lens[$];
    int           wlast_pos[$];

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_awvalid"}, m_awvalid, 0);
        chk({tag, "_wvalid"}, m_wvalid, 0);
        chk({tag, "_bready"}, m_bready, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic run_case(input int id, input vec_t v);
        int n = v.win * v.hin * v.cg;
        int src_idx = 0, bursts = 0, beats = 0, done_cnt = 0, cyc = 0, post = 0, beat = 0;
        bit in_w = 0, pend_b = 0, aw_wait = 0, src_hold = 0;
        logic [31:0] cur_addr = '0, prev_awaddr = '0;
        logic [7:0] cur_len = '0, prev_awlen = '0;
        logic [31:0] exp_a [4] = '{32'h0800_0000, 32'h0800_0200, 32'h0800_0280, 32'h0800_0480};
        logic [7:0]  exp_l [4] = '{8'd15, 8'd3, 8'd15, 8'd3};
        int          exp_wl [4] = '{16, 20, 36, 40};
        mem.delete();
        aw_addrs.delete();
        aw_lens.delete();
        wlast_pos.delete();
        while (1) begin
            @(negedge clk);
            start = (cyc == 0) || (cyc == v.stray);
            if (cyc == 0) begin
                win = DIM_W'(v.win); hin = DIM_W'(v.hin); ch_groups = DIM_W'(v.cg);
                base_addr = v.base; surface_stride = v.ss; line_stride = v.ls;
            end else if (cyc == v.stray) begin
                win = '0; hin = '0; ch_groups = '0; base_addr = '1;
            end
            m_awready = (v.stalls != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_wready  = (v.stalls != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (src_idx < n) begin
                if (!src_hold) s_valid = (v.stalls == 0) || ($urandom_range(0, 3) != 0);
                s_data = pix(src_idx);
            end else begin
                s_valid = 1'b0;
            end
            if (pend_b) begin
                if (!m_bvalid) m_bvalid = (v.stalls == 0) || ($urandom_range(0, 2) == 0);
            end else begin
                m_bvalid = 1'b0;
            end
            m_bresp = (bursts == v.err_burst) ? 2'b10 : 2'b00;
            #1;
            if (cyc == 1) begin
                chk("start_busy", busy, 1);
                chk("start_err_clear", err, 0);
            end
            chk("s_ready_eq_wready", s_ready, in_w ? m_wready : 1'b0);
            if (aw_wait) begin
                chk("aw_hold_valid", m_awvalid, 1);
                chk("aw_hold_addr", m_awaddr, prev_awaddr);
                chk("aw_hold_len", m_awlen, prev_awlen);
            end
            aw_wait = m_awvalid && !m_awready;
            prev_awaddr = m_awaddr;
            prev_awlen = m_awlen;
            if (m_awvalid) chk("aw_single_outstanding", in_w || pend_b, 0);
            if (m_awvalid && m_awready) begin
                chk("awsize", m_awsize, 3'd5);
                chk("awburst", m_awburst, 2'b01);
                chk("awid", m_awid, 0);
                aw_addrs.push_back(m_awaddr);
                aw_lens.push_back(m_awlen);
                in_w = 1; beat = 0; cur_addr = m_awaddr; cur_len = m_awlen;
            end
            if (m_wvalid && m_wready) begin
                chk("w_in_burst", in_w, 1);
                chk("wstrb", m_wstrb, {32{1'b1}});
                chk("wlast", m_wlast, beat == int'(cur_len));
                beats++;
                if (m_wlast) wlast_pos.push_back(beats);
                mem[cur_addr + 32'(beat * PIX_BYTES)] = m_wdata;
                beat++;
                if (beat > int'(cur_len)) begin
                    in_w = 0;
                    pend_b = 1;
                end
            end
            if (s_valid && s_ready) begin
                src_idx++;
                src_hold = 0;
            end else begin
                src_hold = s_valid;
            end
            if (m_bvalid && m_bready) begin
                pend_b = 0;
                bursts++;
            end
            if (done) done_cnt++;
            if (done_cnt > 0) post++;
            cyc++;
            if (post == 4) break;
            if (cyc >= 5000) begin
                checks++; errors++;
                $display("FAIL case%0d_timeout: no done after %0d cycles", id, cyc);
                break;
            end
        end
        start = 1'b0;
        s_valid = 1'b0;
        m_bvalid = 1'b0;
        chk("bursts", 32'(bursts), 32'(v.exp_bursts));
        chk("beats", 32'(beats), 32'(n));
        chk("consumed", 32'(src_idx), 32'(n));
        chk("mem_size", 32'(mem.num()), 32'(n));
        chk("err_final", err, v.exp_err[0]);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("busy_final", busy, 0);
        for (int g = 0; g < v.cg; g++)
            for (int h = 0; h < v.hin; h++)
                for (int w = 0; w < v.win; w++) begin
                    logic [31:0] a;
                    a = v.base + 32'(g) * v.ss + 32'(h) * v.ls + 32'(w * PIX_BYTES);
                    chk("mem_pixel", mem.exists(a) ? mem[a] : {256{1'bx}},
                        pix((g * v.hin + h) * v.win + w));
                end
        if (v.seq == 1) begin
            chk("t2_aw_count", 32'(aw_addrs.size()), 32'd4);
            chk("t2_wlast_count", 32'(wlast_pos.size()), 32'd4);
            for (int i = 0; i < 4 && i < aw_addrs.size(); i++) begin
                chk("t2_awaddr", aw_addrs[i], exp_a[i]);
                chk("t2_awlen", aw_lens[i], exp_l[i]);
            end
            for (int i = 0; i < 4 && i < wlast_pos.size(); i++)
                chk("t2_wlast_beat", 32'(wlast_pos[i]), 32'(exp_wl[i]));
        end else if (v.seq == 2) begin
            for (int i = 0; i < aw_addrs.size(); i++) begin
                chk("t1_awaddr", aw_addrs[i], v.base + 32'(i * 32));
                chk("t1_awlen", aw_lens[i], 0);
            end
        end
        $display("case %0d: win=%0d hin=%0d cg=%0d bursts=%0d beats=%0d err=%0d cycles=%0d",
                 id, v.win, v.hin, v.cg, bursts, beats, err, cyc);
    endtask

    initial begin
        //          win hin cg  base            ss        ls        stl errb stray bursts err seq
        vecs[0] = '{1,  1,  64, 32'h0800_0000, 32'd32,   32'd0,    0, -1,  -1,  64,   0,  2};
        vecs[1] = '{20, 2,  1,  32'h0800_0000, 32'd0,    32'd640,  0, -1,  -1,  4,    0,  1};
        vecs[2] = '{37, 3,  2,  32'h1000_0100, 32'h4000, 32'h1000, 1, -1,  5,   18,   0,  0};
        vecs[3] = '{20, 2,  1,  32'h0800_0000, 32'd0,    32'd640,  1, 1,   -1,  4,    1,  1};
        vecs[4] = '{20, 2,  1,  32'h0800_0000, 32'd0,    32'd640,  0, -1,  -1,  4,    0,  1};
        vecs[5] = '{16, 1,  3,  32'h2000_0000, 32'h800,  32'd0,    1, -1,  -1,  3,    0,  0};
        vecs[6] = '{4,  1,  1,  32'hFFFF_FFC0, 32'd0,    32'd0,    0, -1,  -1,  1,    0,  0};

        repeat (3) @(negedge clk);
        chk_quiet_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_case(i, vecs[i]);

        // Zero-size transfer: done two cycles after start, no AW traffic.
        @(negedge clk);
        win = 16'd5; hin = 16'd5; ch_groups = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        chk("zero_busy", busy, 1);
        chk("zero_done_early", done, 0);
        chk("zero_awvalid_1", m_awvalid, 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("zero_done", done, 1);
        chk("zero_busy_end", busy, 0);
        chk("zero_awvalid_2", m_awvalid, 0);
        @(posedge clk); #1;
        chk("zero_done_pulse", done, 0);
        $display("zero-size transfer finished");

        // Asynchronous reset while a burst is in its W phase.
        @(negedge clk);
        win = 16'd1; hin = 16'd1; ch_groups = 16'd64; base_addr = 32'h0800_0000;
        surface_stride = 32'd32; line_stride = 32'd0;
        start = 1'b1; m_awready = 1'b0; m_wready = 1'b0; s_valid = 1'b0; m_bvalid = 1'b0;
        @(negedge clk);
        start = 1'b0; m_awready = 1'b1;
        #1 chk("rst_seq_awvalid", m_awvalid, 1);
        @(negedge clk);
        m_awready = 1'b0; s_valid = 1'b1; s_data = pix(0);
        #1;
        chk("rst_seq_wvalid", m_wvalid, 1);
        chk("rst_seq_sready", s_ready, 0);
        #2 rst_n = 1'b0;
        #1 chk_quiet_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 1'b0;
        $display("mid-burst reset applied and released");
        run_case(7, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
